stlb_miss_arbiter: RTL and testbench

Arbitrates first-level TLB misses from the instruction TLB (ITLB) and data TLB (DTLB) onto the single request port of the shared TLB. It keeps exactly one miss outstanding. It routes the shared-TLB response back to the requester that owns it. It discards in-flight work on an SFENCE/flush. It sits directly upstream of the shared TLB (64-entry, Sv39) in the MMU, between the 2-entry L1 TLBs and the shared TLB/PTW.

---
 rtl/stlb_miss_arbiter.sv | 144 ++++++++++++++
 tb/tb_stlb_miss_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stlb_miss_arbiter.sv
// Arbitrates ITLB/DTLB misses onto the single shared-TLB request port, keeps one
// miss outstanding, routes the response to its owner and discards work on flush.
module stlb_miss_arbiter #(
  parameter int unsigned VpnWidth  = 27,
  parameter int unsigned AsidWidth = 16,
  parameter int unsigned PteWidth  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [AsidWidth-1:0] asid_i,
  // ITLB side
  input  logic                 itlb_miss_i,
  input  logic [VpnWidth-1:0]  itlb_vpn_i,
  output logic                 itlb_gnt_o,
  output logic                 itlb_rsp_valid_o,
  // DTLB side
  input  logic                 dtlb_miss_i,
  input  logic [VpnWidth-1:0]  dtlb_vpn_i,
  output logic                 dtlb_gnt_o,
  output logic                 dtlb_rsp_valid_o,
  // Shared TLB request
  output logic                 stlb_req_o,
  output logic [VpnWidth-1:0]  stlb_vpn_o,
  output logic [AsidWidth-1:0] stlb_asid_o,
  output logic                 stlb_is_instr_o,
  input  logic                 stlb_gnt_i,
  // Shared TLB response
  input  logic                 stlb_valid_i,
  input  logic [PteWidth-1:0]  stlb_pte_i,
  input  logic [1:0]           stlb_level_i,
  input  logic                 stlb_fault_i,
  // Broadcast to both L1 TLBs
  output logic [PteWidth-1:0]  rsp_pte_o,
  output logic [1:0]           rsp_level_o,
  output logic                 rsp_fault_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } state_e;

  state_e               state_q, state_d;
  logic                 last_instr_q, last_instr_d;
  logic [VpnWidth-1:0]  vpn_q, vpn_d;
  logic [AsidWidth-1:0] asid_q, asid_d;
  logic                 is_instr_q, is_instr_d;

  logic any_miss;
  logic win_instr;

  assign any_miss = itlb_miss_i | dtlb_miss_i;

  // On a tie the side that was not served last wins; a lone requester always wins.
  assign win_instr = (itlb_miss_i && dtlb_miss_i) ? ~last_instr_q : itlb_miss_i;

  // NOTE: every combinational output and next-state value gets a default before the
  // case statement, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d          = state_q;
    last_instr_d     = last_instr_q;
    vpn_d            = vpn_q;
    asid_d           = asid_q;
    is_instr_d       = is_instr_q;
    itlb_gnt_o       = 1'b0;
    dtlb_gnt_o       = 1'b0;
    itlb_rsp_valid_o = 1'b0;
    dtlb_rsp_valid_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_miss && !flush_i) begin
          itlb_gnt_o   = win_instr;
          dtlb_gnt_o   = ~win_instr;
          vpn_d        = win_instr ? itlb_vpn_i : dtlb_vpn_i;
          asid_d       = asid_i;
          is_instr_d   = win_instr;
          last_instr_d = win_instr;
          state_d      = S_REQ;
        end
      end

      S_REQ: begin
        // A flush racing the shared-TLB accept still leaves a response in flight.
        if (flush_i) begin
          state_d = stlb_gnt_i ? S_DROP : S_IDLE;
        end else if (stlb_gnt_i) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (stlb_valid_i) begin
          state_d = S_IDLE;
          if (!flush_i) begin
            itlb_rsp_valid_o = is_instr_q;
            dtlb_rsp_valid_o = ~is_instr_q;
          end
        end else if (flush_i) begin
          state_d = S_DROP;
        end
      end

      S_DROP: begin
        if (stlb_valid_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      last_instr_q <= 1'b1;
      vpn_q        <= '0;
      asid_q       <= '0;
      is_instr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_instr_q <= last_instr_d;
      vpn_q        <= vpn_d;
      asid_q       <= asid_d;
      is_instr_q   <= is_instr_d;
    end
  end

  assign stlb_req_o      = (state_q == S_REQ);
  assign stlb_vpn_o      = vpn_q;
  assign stlb_asid_o     = asid_q;
  assign stlb_is_instr_o = is_instr_q;

  assign rsp_pte_o   = stlb_pte_i;
  assign rsp_level_o = stlb_level_i;
  assign rsp_fault_o = stlb_fault_i;

endmodule

// File: tb/tb_stlb_miss_arbiter.sv
// Directed bench for stlb_miss_arbiter: inputs change 1 ns after each rising edge,
// outputs are compared 1 ns after that, well away from the next edge.
module tb_stlb_miss_arbiter;

  localparam int unsigned VpnWidth  = 27;
  localparam int unsigned AsidWidth = 16;
  localparam int unsigned PteWidth  = 64;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 flush_i;
  logic [AsidWidth-1:0] asid_i;
  logic                 itlb_miss_i;
  logic [VpnWidth-1:0]  itlb_vpn_i;
  logic                 itlb_gnt_o;
  logic                 itlb_rsp_valid_o;
  logic                 dtlb_miss_i;
  logic [VpnWidth-1:0]  dtlb_vpn_i;
  logic                 dtlb_gnt_o;
  logic                 dtlb_rsp_valid_o;
  logic                 stlb_req_o;
  logic [VpnWidth-1:0]  stlb_vpn_o;
  logic [AsidWidth-1:0] stlb_asid_o;
  logic                 stlb_is_instr_o;
  logic                 stlb_gnt_i;
  logic                 stlb_valid_i;
  logic [PteWidth-1:0]  stlb_pte_i;
  logic [1:0]           stlb_level_i;
  logic                 stlb_fault_i;
  logic [PteWidth-1:0]  rsp_pte_o;
  logic [1:0]           rsp_level_o;
  logic                 rsp_fault_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  stlb_miss_arbiter #(
    .VpnWidth (VpnWidth),
    .AsidWidth(AsidWidth),
    .PteWidth (PteWidth)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .asid_i          (asid_i),
    .itlb_miss_i     (itlb_miss_i),
    .itlb_vpn_i      (itlb_vpn_i),
    .itlb_gnt_o      (itlb_gnt_o),
    .itlb_rsp_valid_o(itlb_rsp_valid_o),
    .dtlb_miss_i     (dtlb_miss_i),
    .dtlb_vpn_i      (dtlb_vpn_i),
    .dtlb_gnt_o      (dtlb_gnt_o),
    .dtlb_rsp_valid_o(dtlb_rsp_valid_o),
    .stlb_req_o      (stlb_req_o),
    .stlb_vpn_o      (stlb_vpn_o),
    .stlb_asid_o     (stlb_asid_o),
    .stlb_is_instr_o (stlb_is_instr_o),
    .stlb_gnt_i      (stlb_gnt_i),
    .stlb_valid_i    (stlb_valid_i),
    .stlb_pte_i      (stlb_pte_i),
    .stlb_level_i    (stlb_level_i),
    .stlb_fault_i    (stlb_fault_i),
    .rsp_pte_o       (rsp_pte_o),
    .rsp_level_o     (rsp_level_o),
    .rsp_fault_o     (rsp_fault_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grants, request and response valids packed as {ignt,dgnt,req,irsp,drsp}.
  task automatic check_ctl(input string tag, input logic [4:0] exp);
    check(tag, {59'd0, itlb_gnt_o, dtlb_gnt_o, stlb_req_o, itlb_rsp_valid_o, dtlb_rsp_valid_o},
          {59'd0, exp});
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One tie round: both miss, winner granted, accepted next cycle, answered the one after.
  task automatic tie_round(input string tag, input logic exp_instr);
    next_cycle();
    itlb_miss_i = 1'b1;
    dtlb_miss_i = 1'b1;
    settle();
    check_ctl({tag, "_gnt"}, {exp_instr, ~exp_instr, 3'b000});
    next_cycle();
    if (exp_instr) itlb_miss_i = 1'b0;
    else           dtlb_miss_i = 1'b0;
    stlb_gnt_i = 1'b1;
    settle();
    check_ctl({tag, "_req"}, 5'b00100);
    check({tag, "_owner"}, {63'd0, stlb_is_instr_o}, {63'd0, exp_instr});
    check({tag, "_vpn"}, {37'd0, stlb_vpn_o}, exp_instr ? 64'h111 : 64'h222);
    next_cycle();
    stlb_gnt_i   = 1'b0;
    stlb_valid_i = 1'b1;
    settle();
    check_ctl({tag, "_rsp"}, {3'b000, exp_instr, ~exp_instr});
    next_cycle();
    stlb_valid_i = 1'b0;
    itlb_miss_i  = 1'b0;
    dtlb_miss_i  = 1'b0;
    settle();
  endtask

  task automatic do_reset();
    #3;
    rst_ni = 1'b0;
    #4;
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni       = 1'b0;
    flush_i      = 1'b0;
    asid_i       = '0;
    itlb_miss_i  = 1'b0;
    itlb_vpn_i   = '0;
    dtlb_miss_i  = 1'b0;
    dtlb_vpn_i   = '0;
    stlb_gnt_i   = 1'b0;
    stlb_valid_i = 1'b0;
    stlb_pte_i   = '0;
    stlb_level_i = 2'd0;
    stlb_fault_i = 1'b0;

    // Reset values
    #2;
    check_ctl("rst_ctl", 5'b00000);
    check("rst_vpn", {37'd0, stlb_vpn_o}, 64'h0);
    check("rst_asid", {48'd0, stlb_asid_o}, 64'h0);
    check("rst_owner", {63'd0, stlb_is_instr_o}, 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // ITLB miss alone: grant at 0, req 1..3, stlb grant at 3, response at 5
    next_cycle();
    itlb_miss_i = 1'b1;
    itlb_vpn_i  = 27'h1_2345;
    asid_i      = 16'h7;
    settle();
    check_ctl("i_c0", 5'b10000);
    next_cycle();
    itlb_miss_i = 1'b0;
    asid_i      = 16'h55;
    itlb_vpn_i  = 27'h0;
    settle();
    check_ctl("i_c1", 5'b00100);
    check("i_c1_vpn", {37'd0, stlb_vpn_o}, 64'h1_2345);
    check("i_c1_asid", {48'd0, stlb_asid_o}, 64'h7);
    check("i_c1_owner", {63'd0, stlb_is_instr_o}, 64'h1);
    next_cycle();
    settle();
    check_ctl("i_c2", 5'b00100);
    next_cycle();
    stlb_gnt_i = 1'b1;
    settle();
    check_ctl("i_c3", 5'b00100);
    check("i_c3_vpn", {37'd0, stlb_vpn_o}, 64'h1_2345);
    next_cycle();
    stlb_gnt_i = 1'b0;
    settle();
    check_ctl("i_c4", 5'b00000);
    next_cycle();
    stlb_valid_i = 1'b1;
    stlb_pte_i   = 64'hCF;
    stlb_level_i = 2'd1;
    settle();
    check_ctl("i_c5", 5'b00010);
    check("i_c5_pte", rsp_pte_o, 64'hCF);
    check("i_c5_level", {62'd0, rsp_level_o}, 64'd1);
    next_cycle();
    stlb_valid_i = 1'b0;
    settle();
    check_ctl("i_c6", 5'b00000);

    // Round-robin after reset: DTLB, ITLB, DTLB
    do_reset();
    itlb_vpn_i = 27'h111;
    dtlb_vpn_i = 27'h222;
    tie_round("rr1", 1'b0);
    tie_round("rr2", 1'b1);
    tie_round("rr3", 1'b0);

    // Flush in REQ; flush in IDLE blocks the grant; stray valid in IDLE ignored
    next_cycle();
    dtlb_miss_i = 1'b1;
    settle();
    check_ctl("fr_gnt", 5'b01000);
    next_cycle();
    dtlb_miss_i = 1'b0;
    flush_i     = 1'b1;
    settle();
    check_ctl("fr_req", 5'b00100);
    next_cycle();
    flush_i      = 1'b0;
    stlb_valid_i = 1'b1;
    settle();
    check_ctl("fr_dropped", 5'b00000);
    next_cycle();
    stlb_valid_i = 1'b0;
    dtlb_miss_i  = 1'b1;
    flush_i      = 1'b1;
    settle();
    check_ctl("fr_idle_flush", 5'b00000);
    next_cycle();
    flush_i = 1'b0;
    settle();
    check_ctl("fr_regrant", 5'b01000);
    next_cycle();
    dtlb_miss_i = 1'b0;
    stlb_gnt_i  = 1'b1;
    settle();
    next_cycle();
    stlb_gnt_i   = 1'b0;
    stlb_valid_i = 1'b1;
    settle();
    check_ctl("fr_rsp", 5'b00001);
    next_cycle();
    stlb_valid_i = 1'b0;
    settle();

    // Flush in WAIT, response 4 cycles later is discarded; no grant in DROP
    itlb_miss_i = 1'b1;
    settle();
    check_ctl("fw_gnt", 5'b10000);
    next_cycle();
    itlb_miss_i = 1'b0;
    stlb_gnt_i  = 1'b1;
    settle();
    next_cycle();
    stlb_gnt_i = 1'b0;
    flush_i    = 1'b1;
    settle();
    check_ctl("fw_flush", 5'b00000);
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      flush_i     = 1'b0;
      itlb_miss_i = 1'b1;
      settle();
      check_ctl($sformatf("fw_drop%0d", i), 5'b00000);
    end
    next_cycle();
    stlb_valid_i = 1'b1;
    settle();
    check_ctl("fw_valid", 5'b00000);
    next_cycle();
    stlb_valid_i = 1'b0;
    settle();
    check_ctl("fw_idle", 5'b10000);
    next_cycle();
    itlb_miss_i = 1'b0;
    stlb_gnt_i  = 1'b1;
    settle();
    next_cycle();
    stlb_gnt_i   = 1'b0;
    stlb_valid_i = 1'b1;
    settle();
    check_ctl("fw_rsp", 5'b00010);
    next_cycle();
    stlb_valid_i = 1'b0;
    settle();

    // Flush and valid together in WAIT
    dtlb_miss_i = 1'b1;
    settle();
    check_ctl("fv_gnt", 5'b01000);
    next_cycle();
    dtlb_miss_i = 1'b0;
    stlb_gnt_i  = 1'b1;
    settle();
    next_cycle();
    stlb_gnt_i   = 1'b0;
    flush_i      = 1'b1;
    stlb_valid_i = 1'b1;
    settle();
    check_ctl("fv_suppress", 5'b00000);
    next_cycle();
    flush_i      = 1'b0;
    stlb_valid_i = 1'b0;
    dtlb_miss_i  = 1'b1;
    settle();
    check_ctl("fv_idle", 5'b01000);

    // Flush coinciding with stlb grant in REQ goes to DROP
    next_cycle();
    dtlb_miss_i = 1'b1;
    stlb_gnt_i  = 1'b1;
    flush_i     = 1'b1;
    settle();
    check_ctl("fg_req", 5'b00100);
    next_cycle();
    stlb_gnt_i = 1'b0;
    flush_i    = 1'b0;
    settle();
    check_ctl("fg_drop", 5'b00000);
    next_cycle();
    stlb_valid_i = 1'b1;
    settle();
    check_ctl("fg_valid", 5'b00000);
    next_cycle();
    stlb_valid_i = 1'b0;
    settle();
    check_ctl("fg_idle", 5'b01000);
    next_cycle();
    dtlb_miss_i = 1'b0;
    stlb_gnt_i  = 1'b1;
    settle();
    next_cycle();
    stlb_gnt_i = 1'b0;
    settle();

    // Reset asserted in WAIT
    check("rw_owner_before", {63'd0, stlb_is_instr_o}, 64'h0);
    rst_ni = 1'b0;
    settle();
    check_ctl("rw_ctl", 5'b00000);
    check("rw_vpn", {37'd0, stlb_vpn_o}, 64'h0);
    check("rw_asid", {48'd0, stlb_asid_o}, 64'h0);
    check("rw_owner", {63'd0, stlb_is_instr_o}, 64'h0);
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();
    stlb_valid_i = 1'b1;
    settle();
    check_ctl("rw_stray", 5'b00000);
    next_cycle();
    stlb_valid_i = 1'b0;
    itlb_miss_i  = 1'b1;
    dtlb_miss_i  = 1'b1;
    settle();
    check_ctl("rw_tie", 5'b01000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
